// File: rtl/dcache_if.sv
// Data-cache request port: index phase (req/gnt), tag phase (tag_valid/kill_req),
// and read response (rvalid/rdata). master = load/store unit, slave = responder.
interface dcache_if;
  logic [11:0] address_index;
  logic [43:0] address_tag;
  logic [63:0] data_wdata;
  logic        data_we;
  logic [7:0]  data_be;
  logic        data_req;
  logic        data_gnt;
  logic        kill_req;
  logic        tag_valid;
  logic        data_rvalid;
  logic [63:0] data_rdata;

  modport master (
    output address_index, address_tag, data_wdata, data_we, data_be,
           data_req, kill_req, tag_valid,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  address_index, address_tag, data_wdata, data_we, data_be,
           data_req, kill_req, tag_valid,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/dcache_responder.sv
// Memory-side responder for the split-phase data-cache port with an internal word memory.
// Optional random grant stall via macro DCACHE_RESP_RAND_STALL_EN (16-bit LFSR stall targets).
module dcache_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int GNT_STALL = 0
) (
  input logic      clk,
  input logic      rst,
  dcache_if.slave  bus
);

  localparam int DATA_W = 64;
  localparam int BE_W   = DATA_W / 8;
  localparam int AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] STALL_MAX = 4'(GNT_STALL);

  typedef enum logic [0:0] {ST_IDLE, ST_TAG} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_target;
  logic                w_eligible;
  logic                w_gnt;
  logic                w_commit;
  logic                w_kill;

  logic [11:0]         r_index_p0;
  logic                r_we_p0;
  logic [BE_W-1:0]     r_be_p0;
  logic [DATA_W-1:0]   r_wdata_p0;

  logic [DATA_W-1:0]   r_mem [MEM_WORDS];
  logic [55:0]         w_addr;
  logic [AW-1:0]       w_word;
  logic [DATA_W-1:0]   w_rd_word;
  logic                w_unused_addr;

  logic                r_rvalid_p1;
  logic [DATA_W-1:0]   r_rdata_p1;

  function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_w,
                                                 input logic [DATA_W-1:0] new_w,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

`ifdef DCACHE_RESP_RAND_STALL_EN
  logic [15:0] r_lfsr;

  // Mask to the bit-width of GNT_STALL, then clamp so the target never exceeds it.
  function automatic logic [3:0] clamp_stall(input logic [3:0] raw);
    logic [3:0] m;
    logic [3:0] v;
    m = STALL_MAX | (STALL_MAX >> 1) | (STALL_MAX >> 2) | (STALL_MAX >> 3);
    v = raw & m;
    return (v > STALL_MAX) ? STALL_MAX : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else if (w_gnt) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_target = clamp_stall(r_lfsr[3:0]);
`else
  assign w_target = STALL_MAX;
`endif

  // Tag phase addressing: index comes from the granted request, tag from the current cycle.
  assign w_addr        = {bus.address_tag, r_index_p0};
  assign w_word        = w_addr[3 +: AW];
  assign w_rd_word     = r_mem[w_word];
  assign w_unused_addr = ^{w_addr[55:3+AW], w_addr[2:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_eligible  = 1'b0;
    w_commit    = 1'b0;
    w_kill      = 1'b0;
    case (r_state)
      ST_IDLE: w_eligible = 1'b1;
      ST_TAG: begin
        w_kill     = bus.kill_req;
        w_commit   = bus.tag_valid && !bus.kill_req;
        w_eligible = w_kill || w_commit;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_gnt = !rst && bus.data_req && w_eligible && (r_cnt >= w_target);
    if (w_gnt) begin
      w_state_nxt = ST_TAG;
    end else if (w_eligible) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (!bus.data_req || w_gnt) begin
        r_cnt <= 4'd0;
      end else if (w_eligible && (r_cnt != 4'hF)) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // Stage p0: request fields captured at grant.
  always_ff @(posedge clk) begin
    if (w_gnt) begin
      r_index_p0 <= bus.address_index;
      r_we_p0    <= bus.data_we;
      r_be_p0    <= bus.data_be;
      r_wdata_p0 <= bus.data_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_commit && r_we_p0) begin
      r_mem[w_word] <= merge_be(w_rd_word, r_wdata_p0, r_be_p0);
    end
  end

  // Stage p1: read response, one cycle after the committing tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid_p1 <= 1'b0;
      r_rdata_p1  <= '0;
    end else begin
      r_rvalid_p1 <= w_commit && !r_we_p0;
      r_rdata_p1  <= (w_commit && !r_we_p0) ? w_rd_word : '0;
    end
  end

  assign bus.data_gnt    = w_gnt;
  assign bus.data_rvalid = r_rvalid_p1;
  assign bus.data_rdata  = r_rdata_p1;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed plus randomized bench for dcache_responder against an array-based memory model.
module tb_dcache_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] mdl [16];
  logic [63:0] pexp [$];
  logic [11:0] pidx [4];

  dcache_if bus0 ();
  dcache_if bus1 ();

  dcache_responder #(.MEM_WORDS(16), .GNT_STALL(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dcache_responder #(.MEM_WORDS(1024), .GNT_STALL(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [43:0] tag, input logic [11:0] idx);
    logic [55:0] a;
    a = {tag, idx};
    return int'((a / 56'd8) % 56'd16);
  endfunction

  // One full transaction on bus0; starts and ends just after a rising edge.
  task automatic do_req(input logic we, input logic [11:0] idx, input logic [43:0] tag,
                        input logic [63:0] wd, input logic [7:0] be, input logic kill);
    int n;
    int w;
    logic [63:0] exp;
    logic rd_ok;
    bus0.data_req      = 1'b1;
    bus0.data_we       = we;
    bus0.data_be       = be;
    bus0.data_wdata    = wd;
    bus0.address_index = idx;
    n = 0;
    @(negedge clk);
    while (bus0.data_gnt !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("gnt", 64'(bus0.data_gnt), 64'd1);
    @(posedge clk); #1;
    bus0.data_req      = 1'b0;
    bus0.data_we       = ~we;
    bus0.data_be       = ~be;
    bus0.data_wdata    = {$urandom, $urandom};
    bus0.address_index = 12'($urandom);
    bus0.tag_valid     = 1'b1;
    bus0.address_tag   = tag;
    bus0.kill_req      = kill;
    w   = word_of(tag, idx);
    exp = mdl[w];
    if (!kill && we) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mdl[w][8*b +: 8] = wd[8*b +: 8];
      end
    end
    rd_ok = !we && !kill;
    @(negedge clk);
    check("rvalid_in_tag", 64'(bus0.data_rvalid), 64'd0);
    @(posedge clk); #1;
    bus0.tag_valid = 1'b0;
    bus0.kill_req  = 1'b0;
    @(negedge clk);
    check("rvalid", 64'(bus0.data_rvalid), 64'(rd_ok));
    check("rdata", bus0.data_rdata, rd_ok ? exp : 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus0.data_req = 1'b0; bus0.data_we = 1'b0; bus0.data_be = '0; bus0.data_wdata = '0;
    bus0.address_index = '0; bus0.address_tag = '0; bus0.kill_req = 1'b0; bus0.tag_valid = 1'b0;
    bus1.data_req = 1'b0; bus1.data_we = 1'b0; bus1.data_be = '0; bus1.data_wdata = '0;
    bus1.address_index = '0; bus1.address_tag = '0; bus1.kill_req = 1'b0; bus1.tag_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_gnt", 64'(bus0.data_gnt), 64'd0);
    check("reset_rvalid", 64'(bus0.data_rvalid), 64'd0);
    check("reset_rdata", bus0.data_rdata, 64'd0);
    @(posedge clk); #1;

    // Fill every word so the model is fully defined
    for (int i = 0; i < 16; i++) do_req(1'b1, 12'(i * 8), 44'd0, {$urandom, $urandom}, 8'hFF, 1'b0);

    // Write then read, byte enables
    do_req(1'b1, 12'h010, 44'd0, 64'h1122334455667788, 8'hFF, 1'b0);
    do_req(1'b0, 12'h010, 44'd0, 64'd0, 8'hFF, 1'b0);
    check("wr_rd_model", mdl[2], 64'h1122334455667788);
    do_req(1'b1, 12'h010, 44'd0, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b0);
    do_req(1'b0, 12'h010, 44'd0, 64'd0, 8'h00, 1'b0);
    check("be_model", mdl[2], 64'h11223344AAAAAAAA);

    // Kill a read, then watch for stray rvalid
    do_req(1'b0, 12'h010, 44'd0, 64'd0, 8'hFF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("kill_no_rvalid", 64'(bus0.data_rvalid), 64'd0);
      @(posedge clk); #1;
    end
    do_req(1'b1, 12'h010, 44'd0, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b1);
    do_req(1'b0, 12'h010, 44'd0, 64'd0, 8'hFF, 1'b0);

    // Aliasing: index 0x080 wraps onto word 0
    do_req(1'b1, 12'h080, 44'd0, 64'hCAFE_0000_1234_5678, 8'hFF, 1'b0);
    do_req(1'b0, 12'h000, 44'd0, 64'd0, 8'hFF, 1'b0);
    check("alias_model", mdl[0], 64'hCAFE_0000_1234_5678);

    // Four back-to-back reads with tags in consecutive cycles
    for (int i = 0; i < 4; i++) pidx[i] = 12'($urandom);
    for (int i = 0; i < 6; i++) begin
      bus0.data_req      = (i < 4);
      bus0.address_index = pidx[(i < 4) ? i : 0];
      bus0.data_we       = 1'b0;
      bus0.data_be       = 8'hFF;
      bus0.tag_valid     = (i >= 1 && i <= 4);
      bus0.address_tag   = 44'd0;
      bus0.kill_req      = 1'b0;
      if (i >= 1 && i <= 4) pexp.push_back(mdl[word_of(44'd0, pidx[i-1])]);
      @(negedge clk);
      check("pipe_gnt", 64'(bus0.data_gnt), 64'(i < 4));
      check("pipe_rvalid", 64'(bus0.data_rvalid), 64'(i >= 2));
      if (i >= 2) check("pipe_rdata", bus0.data_rdata, pexp.pop_front());
      @(posedge clk); #1;
    end
    bus0.data_req = 1'b0; bus0.tag_valid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom), 12'($urandom), 44'($urandom % 4), {$urandom, $urandom},
             8'($urandom), ($urandom % 5) == 0);
    end

    // Reset in the tag cycle of a granted read
    bus0.data_req = 1'b1; bus0.data_we = 1'b0; bus0.data_be = 8'hFF; bus0.address_index = 12'h010;
    @(negedge clk);
    check("rst_gnt", 64'(bus0.data_gnt), 64'd1);
    @(posedge clk); #1;
    bus0.data_req = 1'b0; bus0.tag_valid = 1'b1; bus0.address_tag = 44'd0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus0.tag_valid = 1'b0;
    @(negedge clk);
    check("rst_rvalid", 64'(bus0.data_rvalid), 64'd0);
    check("rst_rdata", bus0.data_rdata, 64'd0);
    check("rst_gnt_after", 64'(bus0.data_gnt), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_rvalid2", 64'(bus0.data_rvalid), 64'd0);
    @(posedge clk); #1;
    do_req(1'b0, 12'h010, 44'd0, 64'd0, 8'hFF, 1'b0);

    // Stall of 3 on the second instance
    bus1.data_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_gnt", 64'(bus1.data_gnt), 64'(c == 3));
      @(posedge clk); #1;
    end
    bus1.data_req = 1'b0; bus1.kill_req = 1'b1;
    @(posedge clk); #1;
    bus1.kill_req = 1'b0;
    for (int c = 0; c < 7; c++) begin
      bus1.data_req = (c != 2);
      @(negedge clk);
      check("stall_restart_gnt", 64'(bus1.data_gnt), 64'(c == 6));
      @(posedge clk); #1;
    end
    bus1.data_req = 1'b0; bus1.kill_req = 1'b1;
    @(posedge clk); #1;
    bus1.kill_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
